// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared types and constants for the matrix keypad emulator:
//            FSM state encoding, idle column value, key_code field layout.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_BOUNCE_PRESS = 3'd1,
    ST_HOLD         = 3'd2,
    ST_BOUNCE_REL   = 3'd3,
    ST_GAP          = 3'd4
  } state_t;

  // Column sense is active-low, so "no key" reads as all ones.
  localparam logic [3:0] COL_IDLE = 4'b1111;

  // Field positions within key_code.
  localparam int ROW_MSB = 3;
  localparam int ROW_LSB = 2;
  localparam int COL_MSB = 1;
  localparam int COL_LSB = 0;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Index 0 maps to bit 3, so the bit position is 3 - idx, i.e. ~idx on 2 bits.
  function automatic logic [3:0] one_cold(input logic [1:0] idx);
    logic [3:0] v;
    v       = COL_IDLE;
    v[~idx] = 1'b0;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_bounce_gen.sv
`default_nettype none
// ============================================================================
// Module   : keypad_bounce_gen
// Brief    : Contact chatter source. While active, the output toggles every
//            TOGGLE cycles, starting at start_closed on the first active cycle.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_bounce_gen #(
  parameter int TOGGLE = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic start_closed,
  output logic chatter
);

  localparam int TW = $clog2(TOGGLE) + 1;
  localparam logic [TW-1:0] TOGGLE_LAST = TW'(TOGGLE - 1);

  logic [TW-1:0] tcnt;
  logic          phase;

  // Half-period counter and phase flip; parked at zero between bounce windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt  <= '0;
      phase <= 1'b0;
    end else if (!active) begin
      tcnt  <= '0;
      phase <= 1'b0;
    end else if (tcnt == TOGGLE_LAST) begin
      tcnt  <= '0;
      phase <= ~phase;
    end else begin
      tcnt  <= tcnt + TW'(1);
    end
  end

  assign chatter = start_closed ^ phase;

endmodule
`default_nettype wire

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : keypad_emulator
// Brief    : Emulates one key of a 4x4 active-low matrix keypad. A request is
//            turned into a timed press/hold/release/gap sequence; while the
//            contact is closed the selected column follows the selected row
//            with one cycle of latency.
//            Optional contact bounce: define KEYPAD_EMU_BOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES   = 100000,
  parameter int GAP_CYCLES    = 50000,
  parameter int BOUNCE_CYCLES = 2000,
  parameter int BOUNCE_TOGGLE = 250
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] R,
  output logic [3:0] C,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic       busy
);

  localparam int CNT_W = $clog2(max_of4(HOLD_CYCLES, GAP_CYCLES,
                                        BOUNCE_CYCLES, BOUNCE_TOGGLE)) + 1;
  localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'(BOUNCE_CYCLES - 1);
`endif

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       code;
  logic             contact;
  logic [1:0]       row;
  logic [1:0]       col;

  assign row = code[ROW_MSB:ROW_LSB];
  assign col = code[COL_MSB:COL_LSB];

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic bouncing;
  logic chatter;

  assign bouncing = (state == ST_BOUNCE_PRESS) || (state == ST_BOUNCE_REL);

  keypad_bounce_gen #(
    .TOGGLE(BOUNCE_TOGGLE)
  ) u_bounce_gen (
    .clk          (i_clk),
    .rst_n        (i_rst_n),
    .active       (bouncing),
    .start_closed (state == ST_BOUNCE_PRESS),
    .chatter      (chatter)
  );
`endif

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state, ready flag and contact level.
  always_comb begin
    state_next = state;
    key_ready  = 1'b0;
    contact    = 1'b0;
    case (state)
      ST_IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_next = ST_BOUNCE_PRESS;
`else
          state_next = ST_HOLD;
`endif
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      ST_BOUNCE_PRESS: begin
        contact = chatter;
        if (cnt == BOUNCE_LAST) state_next = ST_HOLD;
      end
      ST_BOUNCE_REL: begin
        contact = chatter;
        if (cnt == BOUNCE_LAST) state_next = ST_GAP;
      end
`endif
      ST_HOLD: begin
        contact = 1'b1;
        if (cnt == HOLD_LAST) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
          state_next = ST_BOUNCE_REL;
`else
          state_next = ST_GAP;
`endif
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy = ~key_ready;

  // Phase counter: restarts on every state change and saturates instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                 cnt <= '0;
    else if (state_next != state) cnt <= '0;
    else if (cnt != CNT_SAT)      cnt <= cnt + CNT_W'(1);
  end

  // Key code is captured only on an accepted request.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                    code <= 4'b0000;
    else if (key_valid && key_ready) code <= key_code;
  end

  // Registered column drive: pull the key's column low when its row is driven.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                C <= COL_IDLE;
    else if (contact && !R[~row]) C <= one_cold(col);
    else                         C <= COL_IDLE;
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_emulator
// Brief    : Self-checking bench for keypad_emulator. A timeline model of the
//            press sequence predicts C, key_ready and busy every cycle.
//            Bounce expectations follow KEYPAD_EMU_BOUNCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;

  localparam int H = 20;
  localparam int G = 8;
  localparam int B = 6;
  localparam int T = 2;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif
  localparam int SEQ_LEN    = BOUNCE ? (2 * B + H + G) : (H + G);
  localparam int HOLD_START = BOUNCE ? B : 0;

  logic       clk;
  logic       rst_n;
  logic [3:0] R;
  logic [3:0] C;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit         m_active;
  int         m_k;
  logic [3:0] m_code;
  logic [3:0] m_c;

  keypad_emulator #(
    .HOLD_CYCLES   (H),
    .GAP_CYCLES    (G),
    .BOUNCE_CYCLES (B),
    .BOUNCE_TOGGLE (T)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .R         (R),
    .C         (C),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Contact level k cycles after acceptance, from the press timeline.
  function automatic bit contact_at(input int k);
    if (BOUNCE) begin
      if (k < B)         return ((k / T) % 2) == 0;
      if (k < B + H)     return 1'b1;
      if (k < 2 * B + H) return ((k - B - H) / T) % 2 == 1;
      return 1'b0;
    end
    return k < H;
  endfunction

  task automatic model_reset();
    m_active = 1'b0;
    m_k      = 0;
    m_code   = 4'b0000;
    m_c      = 4'b1111;
  endtask

  task automatic model_edge(input logic v, input logic [3:0] kc, input logic [3:0] r);
    bit         closed;
    int         row;
    int         col;
    logic [3:0] rr;
    closed = m_active && contact_at(m_k);
    row    = int'(m_code[3:2]);
    col    = int'(m_code[1:0]);
    rr     = r;
    m_c    = 4'b1111;
    if (closed && rr[3 - row] == 1'b0) m_c[3 - col] = 1'b0;
    if (!m_active) begin
      if (v) begin
        m_active = 1'b1;
        m_k      = 0;
        m_code   = kc;
      end
    end else begin
      m_k++;
      if (m_k >= SEQ_LEN) begin
        m_active = 1'b0;
        m_k      = 0;
      end
    end
  endtask

  task automatic cycle(input logic v, input logic [3:0] kc, input logic [3:0] r, input string tag);
    key_valid = v;
    key_code  = kc;
    R         = r;
    @(posedge clk);
    model_edge(v, kc, r);
    #1;
    check_eq({tag, "_c"},     {28'd0, C}, {28'd0, m_c});
    check_eq({tag, "_ready"}, {31'd0, key_ready}, {31'd0, !m_active});
    check_eq({tag, "_busy"},  {31'd0, busy}, {31'd0, m_active});
  endtask

  task automatic run_to_idle(input logic [3:0] r, input string tag);
    for (int i = 0; i < 200 && m_active; i++) cycle(1'b0, 4'($urandom), r, tag);
    check_eq({tag, "_done"}, {31'd0, key_ready}, 32'd1);
  endtask

  function automatic logic [3:0] rand_r();
    logic [3:0] v;
    case ($urandom_range(0, 3))
      0:       v = 4'b1111;
      1:       v = ~(4'b0001 << $urandom_range(0, 3));
      2:       v = 4'($urandom);
      default: begin v = 4'b1111; v[3 - int'(m_code[3:2])] = 1'b0; end
    endcase
    return v;
  endfunction

  logic [3:0] slots [4];

  initial begin
    slots[0] = 4'b0111;
    slots[1] = 4'b1011;
    slots[2] = 4'b1101;
    slots[3] = 4'b1110;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'b0000;
    R         = 4'b1111;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_c",     {28'd0, C}, 32'hF);
    check_eq("rst_ready", {31'd0, key_ready}, 32'd1);
    check_eq("rst_busy",  {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    cycle(1'b0, 4'b0000, 4'b1111, "idle");

    // Single key, row 0 driven throughout
    cycle(1'b1, 4'b0000, 4'b0111, "k0000");
    run_to_idle(4'b0111, "k0000");

    // Rows scanned in 4-cycle slots; only the key's row may produce a column
    cycle(1'b1, 4'b1011, slots[0], "scan");
    for (int i = 1; i < 200 && m_active; i++) cycle(1'b0, 4'b0000, slots[(i / 4) % 4], "scan");
    check_eq("scan_done", {31'd0, key_ready}, 32'd1);

    // Requests while busy are ignored; latched code keeps steering C
    cycle(1'b1, 4'b0110, 4'b1011, "ign");
    for (int i = 0; i < 200 && m_active; i++)
      cycle((i % 3) == 0, 4'b1001, (i % 2) ? 4'b1011 : 4'b1001 & 4'b1011, "ign");
    check_eq("ign_done", {31'd0, key_ready}, 32'd1);

    // Reset in the middle of the hold phase
    cycle(1'b1, 4'b0011, 4'b0111, "mrst");
    for (int i = 0; i < 200 && m_active && m_k < HOLD_START + 10; i++)
      cycle(1'b0, 4'b0000, 4'b0111, "mrst");
    rst_n = 1'b0;
    #1;
    check_eq("mrst_c",     {28'd0, C}, 32'hF);
    check_eq("mrst_ready", {31'd0, key_ready}, 32'd1);
    check_eq("mrst_busy",  {31'd0, busy}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 30; i++) cycle(1'b0, 4'b0011, 4'b0111, "post_rst");

    // key_valid held high across two codes: back-to-back sequences
    cycle(1'b1, 4'b0101, 4'b1011, "b2b_a");
    for (int i = 0; i < 200 && m_active; i++) cycle(1'b1, 4'b0101, 4'b1011, "b2b_a");
    check_eq("b2b_gap_ready", {31'd0, key_ready}, 32'd1);
    cycle(1'b1, 4'b1010, 4'b1101, "b2b_b");
    check_eq("b2b_restart", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 200 && m_active; i++) cycle(1'b1, 4'b1010, 4'b1101, "b2b_b");
    cycle(1'b0, 4'b0000, 4'b1111, "b2b_end");

    // Randomized requests, codes and row drive
    for (int i = 0; i < 1500; i++)
      cycle(($urandom % 4) == 0, 4'($urandom), rand_r(), "rnd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
